// File: rtl/delta_pkg.sv
// Shared definitions for the delta stream parser and its delta memory.
// Holds default widths, the ASCII characters the parser recognises and the parser state encoding.
// No logic beyond a small digit-classification helper.
package delta_pkg;

    localparam int DATA_W_DEF      = 64;
    localparam int ADDR_W_DEF      = 16;
    localparam int MAX_ENTRIES_DEF = 1024;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [2:0] {
        IDLE,
        DIGITS,
        EMIT,
        DONE,
        ERR
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/delta_ram.sv
// Simple dual-port delta memory: parser writes, finder reads.
// Latency: write lands on the clock edge; read data is registered (1 cycle).
// Backpressure: none; accepts a write and a read every cycle. Out-of-range writes are dropped, reads return 0.
//
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out (registered).
module delta_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int            IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    // Full address is range-checked so a narrower index slice can never alias.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        rd_data <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
    end

endmodule

// File: rtl/delta_stream_parser.sv
// Parses an ASCII "+N\n-M\n..." byte stream into signed deltas and writes them to the delta memory.
// Latency: terminating byte accepted at edge N, wr_en high in cycle N+1, count updated at N+2.
// Backpressure: in_ready low during the one-cycle EMIT bubble and in terminal DONE/ERR states.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_byte/in_last byte stream;
//        wr_en/wr_addr/wr_data memory write port; count, done (sticky), error (sticky).
// Optional: define PARSER_SUM_EN to add output 'sum', the running total of written deltas.
module delta_stream_parser
    import delta_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MAX_ENTRIES = MAX_ENTRIES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] count,
    output logic              done,
    output logic              error
`ifdef PARSER_SUM_EN
    ,
    output logic signed [DATA_W-1:0] sum
`endif
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_ENTRIES);

    parser_state_t     state_q, state_nx;
    logic              sign_q, sign_nx;
    logic [DATA_W-1:0] mag_q, mag_nx;
    logic              seen_q, seen_nx;
    logic              last_q, last_nx;
    logic [ADDR_W-1:0] count_q, count_nx;

    logic              ready_int;
    logic              accept;
    logic [7:0]        digit_ch;
    logic [DATA_W-1:0] digit_val;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    assign ready_int = (state_q == IDLE) || (state_q == DIGITS);
    assign accept    = in_valid && ready_int;
    assign digit_ch  = in_byte - CH_0;
    assign digit_val = {{(DATA_W-8){1'b0}}, digit_ch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            seen_q  <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_nx;
            sign_q  <= sign_nx;
            mag_q   <= mag_nx;
            seen_q  <= seen_nx;
            last_q  <= last_nx;
            count_q <= count_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        sign_nx   = sign_q;
        mag_nx    = mag_q;
        seen_nx   = seen_q;
        last_nx   = last_q;
        count_nx  = count_q;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_byte == CH_PLUS || in_byte == CH_MINUS) begin
                        // A sign on the final byte can never be completed.
                        if (in_last) begin
                            state_nx = ERR;
                        end else begin
                            sign_nx  = (in_byte == CH_MINUS);
                            mag_nx   = '0;
                            seen_nx  = 1'b0;
                            state_nx = DIGITS;
                        end
                    end else if (in_byte == CH_NL || in_byte == CH_CR) begin
                        if (in_last) state_nx = DONE;
                    end else begin
                        state_nx = ERR;
                    end
                end
            end

            DIGITS: begin
                if (accept) begin
                    if (is_digit(in_byte)) begin
                        // mag*10 as shifts; wraps modulo 2^DATA_W.
                        mag_nx  = (mag_q << 3) + (mag_q << 1) + digit_val;
                        seen_nx = 1'b1;
                        if (in_last) begin
                            last_nx  = 1'b1;
                            state_nx = EMIT;
                        end
                    end else if (in_byte == CH_CR && !in_last) begin
                        state_nx = DIGITS;
                    end else if ((in_byte == CH_NL || in_byte == CH_CR) && seen_q) begin
                        // A final '\r' closes the number just like '\n'.
                        last_nx  = in_last;
                        state_nx = EMIT;
                    end else begin
                        state_nx = ERR;
                    end
                end
            end

            EMIT: begin
                if ({1'b0, count_q} < MAX_CNT) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = count_q;
                    wr_data_c = sign_q ? -mag_q : mag_q;
                    count_nx  = count_q + ADDR_W'(1);
                    state_nx  = last_q ? DONE : IDLE;
                end else begin
                    state_nx = ERR;
                end
            end

            default: begin
                state_nx = state_q;
            end
        endcase
    end

    // Outputs are forced low while rst is asserted.
    assign in_ready = !rst && ready_int;
    assign wr_en    = !rst && wr_en_c;
    assign wr_addr  = rst ? '0 : wr_addr_c;
    assign wr_data  = rst ? '0 : wr_data_c;
    assign count    = rst ? '0 : count_q;
    assign done     = !rst && (state_q == DONE);
    assign error    = !rst && (state_q == ERR);

`ifdef PARSER_SUM_EN
    logic signed [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (wr_en_c) begin
            sum_q <= sum_q + $signed(wr_data_c);
        end
    end

    assign sum = rst ? '0 : sum_q;
`endif

endmodule

// File: tb/tb_delta_stream_parser.sv
module tb_delta_stream_parser;

    localparam int DW    = 64;
    localparam int AW    = 16;
    localparam int CAP_B = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_last;

    logic          a_in_ready, a_wr_en, a_done, a_error;
    logic [AW-1:0] a_wr_addr, a_count;
    logic [DW-1:0] a_wr_data;
    logic          b_in_ready, b_wr_en, b_done, b_error;
    logic [AW-1:0] b_wr_addr, b_count;
    logic [DW-1:0] b_wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
`ifdef PARSER_SUM_EN
    logic signed [DW-1:0] a_sum, b_sum;
`endif

    always #5 clk = ~clk;

    delta_stream_parser #(.DATA_W(DW), .ADDR_W(AW), .MAX_ENTRIES(1024)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_byte(in_byte), .in_last(in_last), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .count(a_count), .done(a_done), .error(a_error)
`ifdef PARSER_SUM_EN
        , .sum(a_sum)
`endif
    );

    delta_stream_parser #(.DATA_W(DW), .ADDR_W(AW), .MAX_ENTRIES(CAP_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_byte(in_byte), .in_last(in_last), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .count(b_count), .done(b_done), .error(b_error)
`ifdef PARSER_SUM_EN
        , .sum(b_sum)
`endif
    );

    delta_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024)) u_ram (
        .clk(clk), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]    sbuf[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];
    int            bad_idle_a = 0;
    int            bad_idle_b = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Write monitors: every strobe must address the current count and find in_ready low.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr_en) begin
                got_a.push_back(a_wr_data);
                chk("a_wr_addr_eq_count", a_wr_addr, a_count);
                chk("a_ready_low_in_emit", a_in_ready, 0);
            end else if (a_wr_addr !== '0 || a_wr_data !== '0) begin
                bad_idle_a++;
            end
            if (b_wr_en) begin
                got_b.push_back(b_wr_data);
                chk("b_wr_addr_eq_count", b_wr_addr, b_count);
            end else if (b_wr_addr !== '0 || b_wr_data !== '0) begin
                bad_idle_b++;
            end
        end
    end

    task automatic put(input string s);
        for (int k = 0; k < s.len(); k++) sbuf.push_back(s[k]);
    endtask

    task automatic start_case();
        sbuf.delete();
        exp_q.delete();
        got_a.delete();
        got_b.delete();
        bad_idle_a = 0;
        bad_idle_b = 0;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        @(negedge clk);
        if (check) chk("rst_ready_low", a_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_count", a_count, 0);
            chk("rst_done", a_done, 0);
            chk("rst_error", a_error, 0);
            chk("rst_wr_en", a_wr_en, 0);
            chk("rst_ready_idle", a_in_ready, 1);
        end
    endtask

    // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
    task automatic send_bytes(input bit last_at_end, input int gap_mode);
        int waited;
        for (int i = 0; i < sbuf.size(); i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = sbuf[i];
            in_last  = last_at_end && (i == sbuf.size() - 1);
            waited   = 0;
            while (!a_in_ready && !a_error && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (a_error) begin
                in_valid = 1'b0;
                break;
            end
            if (waited >= 8) begin
                chk("handshake_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Capacity rule for the small instance: only the first CAP_B deltas fit.
    task automatic finish_case(input string name, input bit exp_err);
        int            w;
        int            nb;
        bit            err_b;
        logic [DW-1:0] sa, sb;
        w = 0;
        while (!((a_done || a_error) && (b_done || b_error)) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({name, ":settle"}, w < 40, 1);
        nb    = (exp_q.size() < CAP_B) ? exp_q.size() : CAP_B;
        err_b = exp_err || (exp_q.size() > CAP_B);
        sa    = '0;
        sb    = '0;
        chk({name, ":a_done"}, a_done, !exp_err);
        chk({name, ":a_error"}, a_error, exp_err);
        chk({name, ":a_count"}, a_count, exp_q.size());
        chk({name, ":a_nwrites"}, got_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            sa += exp_q[i];
            if (i < got_a.size()) chk({name, ":a_data"}, got_a[i], exp_q[i]);
        end
        chk({name, ":b_done"}, b_done, !err_b);
        chk({name, ":b_error"}, b_error, err_b);
        chk({name, ":b_count"}, b_count, nb);
        chk({name, ":b_nwrites"}, got_b.size(), nb);
        for (int i = 0; i < nb; i++) begin
            sb += exp_q[i];
            if (i < got_b.size()) chk({name, ":b_data"}, got_b[i], exp_q[i]);
        end
        chk({name, ":a_idle_bus"}, bad_idle_a, 0);
        chk({name, ":b_idle_bus"}, bad_idle_b, 0);
`ifdef PARSER_SUM_EN
        chk({name, ":a_sum"}, a_sum, sa);
        chk({name, ":b_sum"}, b_sum, sb);
`endif
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            chk({name, ":ram"}, rd_data, exp_q[i]);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mag;
        bit          neg;
        bit          notrail;
        int          n;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        rd_addr  = '0;

        // Four deltas; also checks write/count latency on the final line.
        do_reset(1);
        start_case();
        put("+1\n-2\n+3\n+1\n");
        exp_q = '{64'd1, -64'd2, 64'd3, 64'd1};
        send_bytes(1, 0);
        chk("lat_wr_en_n1", a_wr_en, 1);
        chk("lat_count_n1", a_count, 3);
        @(negedge clk);
        chk("lat_count_n2", a_count, 4);
        chk("lat_wr_en_n2", a_wr_en, 0);
        finish_case("four_lines", 0);

        // CRLF, blank line, no trailing newline, in_valid toggling.
        do_reset(0);
        start_case();
        put("-17\r\n\n+0");
        exp_q = '{64'hFFFF_FFFF_FFFF_FFEF, 64'd0};
        send_bytes(1, 1);
        finish_case("crlf_notrail", 0);
        chk("done_ready_low", a_in_ready, 0);

        // Malformed digit.
        do_reset(0);
        start_case();
        put("+12a\n");
        send_bytes(1, 0);
        finish_case("bad_char", 1);
        repeat (3) @(negedge clk);
        chk("err_ready_low", a_in_ready, 0);

        // Overflow for the small instance.
        do_reset(0);
        start_case();
        put("+5\n+6\n+7\n");
        exp_q = '{64'd5, 64'd6, 64'd7};
        send_bytes(1, 0);
        finish_case("capacity", 0);

        // Reset mid-number discards the partial value.
        do_reset(0);
        start_case();
        put("+99");
        send_bytes(0, 0);
        do_reset(0);
        chk("mid_rst_no_write", got_a.size(), 0);
        sbuf.delete();
        put("-3\n");
        exp_q = '{-64'd3};
        send_bytes(1, 0);
        finish_case("mid_reset", 0);

        // Empty file.
        do_reset(0);
        start_case();
        put("\n");
        send_bytes(1, 0);
        finish_case("empty", 0);

        // Sign with no digits.
        do_reset(0);
        start_case();
        put("+\n");
        send_bytes(1, 0);
        finish_case("sign_only", 1);

        // Dangling sign at end of file.
        do_reset(0);
        start_case();
        put("+4\n-");
        exp_q = '{64'd4};
        send_bytes(1, 0);
        finish_case("dangling_sign", 1);

        // Missing sign.
        do_reset(0);
        start_case();
        put("5\n");
        send_bytes(1, 0);
        finish_case("no_sign", 1);

        // Magnitude wraps modulo 2^64: 2^64 + 5 -> 5.
        do_reset(0);
        start_case();
        put("+18446744073709551621\n");
        exp_q = '{64'd5};
        send_bytes(1, 0);
        finish_case("wrap", 0);

        // Randomised well-formed files; expected deltas are the generated values.
        for (int t = 0; t < 8; t++) begin
            do_reset(0);
            start_case();
            n       = $urandom_range(1, 5);
            notrail = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < n; k++) begin
                mag = {$urandom, $urandom} >> $urandom_range(0, 63);
                neg = $urandom_range(0, 1) == 1;
                put(neg ? "-" : "+");
                put($sformatf("%0d", mag));
                exp_q.push_back(neg ? -mag : mag);
                if (k == n - 1 && notrail) break;
                if ($urandom_range(0, 2) == 0) put("\r");
                put("\n");
                if ($urandom_range(0, 3) == 0) put("\n");
            end
            send_bytes(1, 2);
            finish_case($sformatf("random%0d", t), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
